md_unit_e: RTL and testbench

- Execute-stage multiply/divide unit; sits directly downstream of the D→E flow register and consumes its E-stage operands and decoded md opcode.
- Owns architectural HI/LO and models multi-cycle mult/div latency with a busy counter.
- Supplies the D-stage stall request for md-class instructions.
- Supplies the HI/LO read value to the E-stage result mux for mfhi/mflo.

---
 rtl/md_unit_e_pkg.sv | 30 +++
 rtl/md_unit_e_arith.sv | 63 ++++++
 rtl/md_unit_e.sv | 105 ++++++++++
 tb/tb_md_unit_e.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_e_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// opcode encoding, default latencies and opcode classification.
package md_defs;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the opcodes that launch a multi-cycle arithmetic operation.
    function automatic logic is_start_op(input logic [3:0] op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_unit_e_arith.sv
// Combinational mult/div datapath: produces {hi,lo} and a divide-by-zero flag.
// Division works on magnitudes so the 0x80000000 / -1 case falls out naturally.
module md_arith
    import md_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] smul_s;
    logic        [63:0] umul_s;
    logic        [31:0] a_mag_s;
    logic        [31:0] b_mag_s;
    logic        [31:0] b_div_s;
    logic        [31:0] q_mag_s;
    logic        [31:0] r_mag_s;

    assign smul_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign umul_s = {32'd0, rs} * {32'd0, rt};

    // Operand magnitudes and a zero-safe divisor for the shared divider.
    always_comb begin
        a_mag_s = rs;
        b_mag_s = rt;
        if (op == MD_DIV) begin
            a_mag_s = rs[31] ? (32'd0 - rs) : rs;
            b_mag_s = rt[31] ? (32'd0 - rt) : rt;
        end else begin
            a_mag_s = rs;
            b_mag_s = rt;
        end
        b_div_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        q_mag_s = a_mag_s / b_div_s;
        r_mag_s = a_mag_s % b_div_s;
    end

    // Result selection by opcode; quotient sign from operand signs, remainder from dividend.
    always_comb begin
        result   = 64'd0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  result = smul_s;
            MD_MULTU: result = umul_s;
            MD_DIV: begin
                result[31:0]  = (rs[31] ^ rt[31]) ? (32'd0 - q_mag_s) : q_mag_s;
                result[63:32] = rs[31] ? (32'd0 - r_mag_s) : r_mag_s;
                div_zero      = (rt == 32'd0);
            end
            MD_DIVU: begin
                result   = {r_mag_s, q_mag_s};
                div_zero = (rt == 32'd0);
            end
            default: begin
                result   = 64'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_e.sv
// Execute-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// busy counter and raises the D-stage stall for md-class instructions.
module md_unit_e
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdop_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        mdclass_D,
    output logic        busy_E,
    output logic        start_E,
    output logic [31:0] hi_E,
    output logic [31:0] lo_E,
    output logic [31:0] mdout_E,
    output logic        stall_md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_dz_r;
    logic [63:0]      arith_res_s;
    logic             arith_dz_s;
    logic             accept_s;
    logic             idle_s;
    logic [CNT_W-1:0] load_s;

    md_arith u_arith (
        .op       (mdop_E),
        .rs       (rs_E),
        .rt       (rt_E),
        .result   (arith_res_s),
        .div_zero (arith_dz_s)
    );

    // A start is taken when idle or in the final busy cycle (back-to-back issue).
    always_comb begin
        idle_s   = (cnt_r == CNT_W'(0));
        start_E  = is_start_op(mdop_E);
        accept_s = start_E && (cnt_r <= CNT_W'(1));
        if ((mdop_E == MD_DIV) || (mdop_E == MD_DIVU)) begin
            load_s = CNT_W'(DIV_CYCLES);
        end else begin
            load_s = CNT_W'(MULT_CYCLES);
        end
    end

    // Busy counter, pending result capture and HI/LO architectural update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r     <= CNT_W'(0);
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_dz_r <= 1'b0;
        end else begin
            if (!idle_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
                if ((cnt_r == CNT_W'(1)) && !pend_dz_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                cnt_r     <= load_s;
                pend_hi_r <= arith_res_s[63:32];
                pend_lo_r <= arith_res_s[31:0];
                pend_dz_r <= arith_dz_s;
            end else if (idle_s && (mdop_E == MD_MTHI)) begin
                hi_r <= rs_E;
            end else if (idle_s && (mdop_E == MD_MTLO)) begin
                lo_r <= rs_E;
            end else begin
                pend_dz_r <= pend_dz_r;
            end
        end
    end

    // Read mux and hazard outputs.
    always_comb begin
        busy_E   = (cnt_r != CNT_W'(0));
        hi_E     = hi_r;
        lo_E     = lo_r;
        stall_md = mdclass_D & (start_E | busy_E);
        case (mdop_E)
            MD_MFHI: mdout_E = hi_r;
            MD_MFLO: mdout_E = lo_r;
            default: mdout_E = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_unit_e.sv
// Self-checking bench for md_unit_e: directed scenarios plus a randomized run
// compared against an edge-count based reference model.
module tb_md_unit_e;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  mdop_E = 4'd0;
    logic [31:0] rs_E = 32'd0;
    logic [31:0] rt_E = 32'd0;
    logic        mdclass_D = 1'b0;
    logic        busy_E, start_E, stall_md;
    logic [31:0] hi_E, lo_E, mdout_E;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: edge count, completion edge, pending result.
    int          e = 0;
    int          m_done = 0;
    logic        m_pv = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    logic        m_pdz = 1'b0;

    md_unit_e dut (
        .clk(clk), .reset(reset), .mdop_E(mdop_E), .rs_E(rs_E), .rt_E(rt_E),
        .mdclass_D(mdclass_D), .busy_E(busy_E), .start_E(start_E), .hi_E(hi_E),
        .lo_E(lo_E), .mdout_E(mdout_E), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    function automatic void ref_result(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] h,
                                       output logic [31:0] l, output logic dz);
        longint p;
        int     q, r;
        h = 32'd0; l = 32'd0; dz = 1'b0; p = 64'sd0;
        if (op == 4'd1) begin
            p = longint'($signed(a)) * longint'($signed(b));
            h = p[63:32]; l = p[31:0];
        end else if (op == 4'd2) begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            h = p[63:32]; l = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else if (op == 4'd3) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                l = 32'h80000000; h = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                l = q; h = r;
            end
        end else begin
            l = a / b; h = a % b;
        end
    endfunction

    function automatic logic ref_start(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mdc);
        mdop_E = op; rs_E = a; rt_E = b; mdclass_D = mdc;
        #1;
    endtask

    // One clock edge; the model advances using the inputs present at the edge.
    task automatic edge_step();
        @(posedge clk);
        e++;
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_pv = 1'b0; m_done = e;
        end else begin
            if (m_pv && e == m_done) begin
                if (!m_pdz) begin m_hi = m_phi; m_lo = m_plo; end
                m_pv = 1'b0;
            end
            if (ref_start(mdop_E) && e >= m_done) begin
                ref_result(mdop_E, rs_E, rt_E, m_phi, m_plo, m_pdz);
                m_pv = 1'b1;
                m_done = e + ((mdop_E >= 4'd3) ? 10 : 5);
            end else if (mdop_E == 4'd7 && e > m_done) begin
                m_hi = rs_E;
            end else if (mdop_E == 4'd8 && e > m_done) begin
                m_lo = rs_E;
            end
        end
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int busy_n, input string nm);
        apply(op, a, b, 1'b0);
        edge_step();
        for (int i = 0; i < busy_n; i++) begin
            n_checks++;
            if (busy_E !== 1'b1) begin
                n_fail++; $display("FAIL %s_busy[%0d]: got %0b want 1", nm, i, busy_E);
            end
            apply(4'd0, 32'd0, 32'd0, 1'b0);
            edge_step();
        end
        n_checks++;
        if (busy_E !== 1'b0) begin
            n_fail++; $display("FAIL %s_done: busy got %0b want 0", nm, busy_E);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(4'd0, 32'd0, 32'd0, 1'b1);
        edge_step(); edge_step();
        n_checks++;
        if (busy_E !== 1'b0 || hi_E !== 32'd0 || lo_E !== 32'd0 || stall_md !== 1'b0) begin
            n_fail++; $display("FAIL reset: busy=%0b hi=%h lo=%h stall=%0b want 0/0/0/0",
                               busy_E, hi_E, lo_E, stall_md);
        end
        reset = 1'b1;
    endtask

    task automatic test_mult();
        apply(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        n_checks++;
        if (start_E !== 1'b1) begin n_fail++; $display("FAIL mult_start: got %0b want 1", start_E); end
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, "mult");
        n_checks++;
        if (hi_E !== 32'hFFFFFFFF || lo_E !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL mult_val: got %h_%h want ffffffff_fffffffa", hi_E, lo_E);
        end
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, 5, "multu");
        n_checks++;
        if (hi_E !== 32'h00000002 || lo_E !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL multu_val: got %h_%h want 00000002_fffffffa", hi_E, lo_E);
        end
    endtask

    task automatic test_div();
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, "div");
        n_checks++;
        if (hi_E !== 32'hFFFFFFFF || lo_E !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_val: got %h_%h want ffffffff_fffffffd", hi_E, lo_E);
        end
        run_op(4'd4, 32'd7, 32'd0, 10, "divu0");
        n_checks++;
        if (hi_E !== 32'hFFFFFFFF || lo_E !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL divu_zero: got %h_%h want ffffffff_fffffffd", hi_E, lo_E);
        end
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "divovf");
        n_checks++;
        if (hi_E !== 32'd0 || lo_E !== 32'h80000000) begin
            n_fail++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", hi_E, lo_E);
        end
    endtask

    task automatic test_stall();
        apply(4'd1, 32'h00010000, 32'h00030000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (stall_md !== 1'b1) begin
                n_fail++; $display("FAIL stall_on[%0d]: got %0b want 1", i, stall_md);
            end
            edge_step();
            apply(4'd0, 32'd0, 32'd0, 1'b1);
        end
        n_checks++;
        if (stall_md !== 1'b0) begin n_fail++; $display("FAIL stall_off: got %0b want 0", stall_md); end
        apply(4'd5, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (mdout_E !== 32'd3) begin n_fail++; $display("FAIL mfhi_product: got %h want 00000003", mdout_E); end
        edge_step();
    endtask

    task automatic test_mt_mf();
        apply(4'd7, 32'h12345678, 32'd0, 1'b0);
        edge_step();
        apply(4'd5, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (mdout_E !== 32'h12345678 || busy_E !== 1'b0) begin
            n_fail++; $display("FAIL mthi_mfhi: got %h busy %0b want 12345678 0", mdout_E, busy_E);
        end
        apply(4'd6, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (mdout_E !== 32'd0) begin n_fail++; $display("FAIL mflo_unchanged: got %h want 00000000", mdout_E); end
        apply(4'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (mdout_E !== 32'd0) begin n_fail++; $display("FAIL mdout_none: got %h want 0", mdout_E); end
        edge_step();
    endtask

    task automatic test_reset_mid();
        apply(4'd3, 32'd100, 32'd7, 1'b0);
        edge_step();
        apply(4'd0, 32'd0, 32'd0, 1'b0);
        edge_step(); edge_step();
        reset = 1'b0;
        edge_step();
        reset = 1'b1;
        n_checks++;
        if (busy_E !== 1'b0 || hi_E !== 32'd0 || lo_E !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid: busy=%0b hi=%h lo=%h want 0", busy_E, hi_E, lo_E);
        end
        for (int i = 0; i < 12; i++) edge_step();
        n_checks++;
        if (hi_E !== 32'd0 || lo_E !== 32'd0) begin
            n_fail++; $display("FAIL reset_late_write: hi=%h lo=%h want 0", hi_E, lo_E);
        end
    endtask

    task automatic test_back_to_back();
        apply(4'd1, 32'd2, 32'd3, 1'b0);
        edge_step();
        apply(4'd8, 32'hDEADBEEF, 32'd0, 1'b0);
        edge_step();
        apply(4'd0, 32'd0, 32'd0, 1'b0);
        edge_step(); edge_step(); edge_step();
        n_checks++;
        if (lo_E !== 32'd0) begin n_fail++; $display("FAIL busy_ignore_mt: lo=%h want 0", lo_E); end
        apply(4'd2, 32'd5, 32'd7, 1'b0);
        n_checks++;
        if (busy_E !== 1'b1) begin n_fail++; $display("FAIL b2b_lastbusy: got %0b want 1", busy_E); end
        edge_step();
        n_checks++;
        if (busy_E !== 1'b1 || hi_E !== 32'd0 || lo_E !== 32'd6) begin
            n_fail++; $display("FAIL b2b_first: busy=%0b hi=%h lo=%h want 1 0 6", busy_E, hi_E, lo_E);
        end
        apply(4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) edge_step();
        n_checks++;
        if (busy_E !== 1'b0 || lo_E !== 32'd35) begin
            n_fail++; $display("FAIL b2b_second: busy=%0b lo=%h want 0 23", busy_E, lo_E);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        mdc, exp_busy;
        logic [31:0] exp_out;
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 2) == 0) op = 4'd0;
            a   = $urandom();
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            mdc = 1'($urandom_range(0, 1));
            apply(op, a, b, mdc);
            exp_busy = (e < m_done);
            exp_out  = (op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'd0);
            n_checks++;
            if (start_E !== ref_start(op) || stall_md !== (mdc & (ref_start(op) | exp_busy))
                || mdout_E !== exp_out) begin
                n_fail++; $display("FAIL rand_comb[%0d]: start=%0b stall=%0b out=%h want %0b %0b %h",
                                   i, start_E, stall_md, mdout_E, ref_start(op),
                                   mdc & (ref_start(op) | exp_busy), exp_out);
            end
            edge_step();
            n_checks++;
            if (busy_E !== (e < m_done) || hi_E !== m_hi || lo_E !== m_lo) begin
                n_fail++; $display("FAIL rand_state[%0d]: busy=%0b hi=%h lo=%h want %0b %h %h",
                                   i, busy_E, hi_E, lo_E, (e < m_done), m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt_mf();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
